// File: rtl/led_pwm_pkg.sv
// led_pwm_pkg: register offsets, CTRL bit positions and field widths shared by led_pwm and its channels
package led_pwm_pkg;
  localparam int DUTY_W = 8;
  localparam int PRESCALE_W = 16;
  localparam logic [2:0] ADDR_DUTY_R = 3'd0;
  localparam logic [2:0] ADDR_DUTY_G = 3'd1;
  localparam logic [2:0] ADDR_DUTY_B = 3'd2;
  localparam logic [2:0] ADDR_CTRL = 3'd3;
  localparam logic [2:0] ADDR_PRESCALE = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;
  localparam int CTRL_EN = 0;
  localparam int CTRL_BLINK = 1;
  typedef logic [DUTY_W-1:0] duty_t;
endpackage

// File: rtl/led_pwm_channel.sv
// led_pwm_channel: active-duty register, pwm comparator and registered LED pin for one colour
module led_pwm_channel
  import led_pwm_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  gate,
  input  duty_t shadow,
  input  duty_t pwm_cnt,
  output logic  pin
);
  duty_t active;
  always_ff @(posedge clk)
    if (rst) begin
      active <= '0;
      pin <= ACTIVE_LOW;
    end else begin
      active <= load ? shadow : active;
      pin <= (gate && pwm_cnt < active) ^ ACTIVE_LOW;
    end
endmodule

// File: rtl/led_pwm.sv
// led_pwm: register-mapped three-channel LED PWM with prescaler, double-buffered duty and blink
module led_pwm
  import led_pwm_pkg::*;
#(
  parameter logic [15:0] PRESCALE_RST = 16'd0,
  parameter int BLINK_PERIODS = 64,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [2:0]  addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        rvalid,
  output logic        led_red,
  output logic        led_green,
  output logic        led_blue
);
  localparam duty_t BP_LAST = duty_t'(BLINK_PERIODS - 1);
  duty_t duty [3];
  logic [1:0] ctrl;
  logic [PRESCALE_W-1:0] prescale, pre_cnt;
  duty_t pwm_cnt, blink_cnt;
  logic blink_phase, en, blink_en, tick, wrap, wr_pre;
  logic [15:0] rd_val;
  logic [2:0] pins;
  assign en = ctrl[CTRL_EN];
  assign blink_en = ctrl[CTRL_BLINK];
  assign tick = en && pre_cnt == prescale;
  assign wrap = tick && pwm_cnt == '1;
  assign wr_pre = wr_en && addr == ADDR_PRESCALE;
  always_comb
    rd_val = addr == ADDR_DUTY_R   ? 16'(duty[0]) :
             addr == ADDR_DUTY_G   ? 16'(duty[1]) :
             addr == ADDR_DUTY_B   ? 16'(duty[2]) :
             addr == ADDR_CTRL     ? 16'(ctrl) :
             addr == ADDR_PRESCALE ? prescale :
             addr == ADDR_STATUS   ? {7'd0, blink_phase, pwm_cnt} : '0;
  always_ff @(posedge clk)
    if (rst) begin
      duty <= '{default: '0};
      ctrl <= '0;
      prescale <= PRESCALE_RST;
      rdata <= '0;
      rvalid <= 1'b0;
    end else begin
      if (wr_en && addr <= ADDR_DUTY_B) duty[addr[1:0]] <= wdata[DUTY_W-1:0];
      if (wr_en && addr == ADDR_CTRL) ctrl <= wdata[1:0];
      if (wr_pre) prescale <= wdata;
      rvalid <= rd_en;
      if (rd_en) rdata <= rd_val;
    end
  // Timebase collapses to zero whenever the block is disabled
  always_ff @(posedge clk)
    if (rst || !en) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
      blink_cnt <= '0;
      blink_phase <= 1'b0;
    end else begin
      pre_cnt <= (tick || wr_pre) ? '0 : pre_cnt + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
      if (!blink_en) begin
        blink_cnt <= '0;
        blink_phase <= 1'b0;
      end else if (wrap) begin
        blink_cnt <= blink_cnt == BP_LAST ? '0 : blink_cnt + 1'b1;
        if (blink_cnt == BP_LAST) blink_phase <= ~blink_phase;
      end
    end
  for (genvar i = 0; i < 3; i++) begin : g_ch
    led_pwm_channel #(.ACTIVE_LOW(ACTIVE_LOW)) u_ch (
      .clk(clk),
      .rst(rst),
      .load(!en || wrap),
      .gate(en && !blink_phase),
      .shadow(duty[i]),
      .pwm_cnt(pwm_cnt),
      .pin(pins[i])
    );
  end
  assign {led_blue, led_green, led_red} = pins;
endmodule

// File: tb/tb_led_pwm.sv
// tb_led_pwm: randomized and directed checks of led_pwm against a tick/period-count model
module tb_led_pwm;
  localparam int BP = 2;
  localparam bit AL = 1'b1;
  logic clk = 0, rst = 1, wr_en = 0, rd_en = 0;
  logic [2:0] addr = 0;
  logic [15:0] wdata = 0, rdata;
  logic rvalid, led_red, led_green, led_blue;
  int vectors = 0, miscompares = 0;
  bit chk_on = 0;

  led_pwm #(.PRESCALE_RST(16'd3), .BLINK_PERIODS(BP), .ACTIVE_LOW(AL)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rvalid(rvalid), .led_red(led_red), .led_green(led_green), .led_blue(led_blue)
  );

  always #5 clk = ~clk;

  // Model: total ticks since enable give pwm position; completed periods give blink phase
  int m_duty [3], m_act [3];
  int m_ctrl, m_pre, pcnt, ticks, wraps, ph;
  logic [15:0] m_rdata;
  logic m_rvalid;
  logic [2:0] m_pins, lit;

  function automatic logic [15:0] m_read(input logic [2:0] a);
    if (a <= 2) return 16'(m_duty[a]);
    if (a == 3) return 16'(m_ctrl);
    if (a == 4) return 16'(m_pre);
    if (a == 5) return 16'((ph << 8) + ticks % 256);
    return 16'd0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_duty = '{0, 0, 0};
      m_act = '{0, 0, 0};
      m_ctrl = 0; m_pre = 3; pcnt = 0; ticks = 0; wraps = 0;
      m_rdata = 0; m_rvalid = 0; m_pins = {3{AL}};
    end else begin
      ph = (wraps / BP) % 2;
      for (int c = 0; c < 3; c++) lit[c] = m_ctrl[0] && ph == 0 && (ticks % 256) < m_act[c];
      m_rvalid = rd_en;
      if (rd_en) m_rdata = m_read(addr);
      m_pins = lit ^ {3{AL}};
      if (!m_ctrl[0]) begin
        pcnt = 0; ticks = 0; wraps = 0; m_act = m_duty;
      end else begin
        if (pcnt == m_pre) begin
          pcnt = 0;
          ticks++;
          if (ticks % 256 == 0) begin
            m_act = m_duty;
            if (m_ctrl[1]) wraps++;
          end
        end else pcnt++;
        if (!m_ctrl[1]) wraps = 0;
      end
      if (wr_en && addr == 4) pcnt = 0;
      if (wr_en && addr <= 2) m_duty[addr] = int'(wdata[7:0]);
      if (wr_en && addr == 3) m_ctrl = int'(wdata[1:0]);
      if (wr_en && addr == 4) m_pre = int'(wdata);
    end
  end

  always @(negedge clk)
    if (chk_on) begin
      vectors++;
      if ({rvalid, rdata, led_blue, led_green, led_red} !== {m_rvalid, m_rdata, m_pins}) begin
        miscompares++;
        $display("FAIL cycle t=%0t: rvalid=%b rdata=%h pins(bgr)=%b, expected rvalid=%b rdata=%h pins=%b",
                 $time, rvalid, rdata, {led_blue, led_green, led_red}, m_rvalid, m_rdata, m_pins);
      end
    end

  task automatic expect_eq(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic r, input logic [2:0] a, input logic [15:0] d);
    wr_en = w; rd_en = r; addr = a; wdata = d;
    @(negedge clk);
    wr_en = 0; rd_en = 0;
  endtask

  int n;

  initial begin
    repeat (2) @(negedge clk);
    chk_on = 1;
    rst = 0;
    expect_eq("reset_pins", {led_blue, led_green, led_red}, 7);
    drive(0, 1, 4, 0);
    expect_eq("rd_prescale_rvalid", rvalid, 1);
    expect_eq("rd_prescale_data", rdata, 3);
    @(negedge clk);
    expect_eq("rvalid_drop", rvalid, 0);
    expect_eq("rdata_hold", rdata, 3);
    drive(1, 0, 4, 0);
    drive(1, 0, 0, 16'hff40);
    drive(1, 0, 3, 16'hfff1);
    repeat (10) @(negedge clk);
    n = 0;
    repeat (256) begin
      n += (led_red == 0);
      @(negedge clk);
    end
    expect_eq("red_duty64_lit", n, 64);
    n = 0;
    repeat (256) begin
      n += (led_green && led_blue);
      @(negedge clk);
    end
    expect_eq("green_blue_dark", n, 256);
    drive(1, 0, 3, 0);
    drive(1, 0, 1, 10);
    drive(1, 0, 3, 1);
    repeat (50) @(negedge clk);
    drive(1, 0, 1, 200);
    repeat (300) @(negedge clk);
    n = 0;
    repeat (256) begin
      n += (led_green == 0);
      @(negedge clk);
    end
    expect_eq("green_new_duty200", n, 200);
    drive(1, 0, 3, 0);
    drive(1, 0, 2, 255);
    drive(1, 0, 3, 3);
    repeat (5) @(negedge clk);
    n = 0;
    repeat (1024) begin
      n += (led_blue == 0);
      @(negedge clk);
    end
    expect_eq("blue_blink_lit", n, 510);
    drive(1, 0, 3, 0);
    drive(1, 0, 0, 16'h11);
    drive(1, 1, 0, 16'h22);
    expect_eq("rd_wr_same_old", rdata, 16'h11);
    drive(0, 1, 0, 0);
    expect_eq("rd_after_wr_new", rdata, 16'h22);
    drive(0, 1, 6, 0);
    expect_eq("rd_unused_addr", rdata, 0);
    for (int c = 0; c < 3; c++) drive(1, 0, 3'(c), 255);
    drive(1, 0, 3, 1);
    repeat (100) @(negedge clk);
    expect_eq("all_lit_before_rst", {led_blue, led_green, led_red}, 0);
    rst = 1;
    @(negedge clk);
    expect_eq("pins_after_rst", {led_blue, led_green, led_red}, 7);
    rst = 0;
    drive(0, 1, 5, 0);
    expect_eq("status_after_rst", rdata, 0);
    repeat (3000) begin
      rst = ($urandom % 500) == 0;
      wr_en = ($urandom % 4) == 0;
      rd_en = ($urandom % 3) == 0;
      addr = 3'($urandom % 8);
      wdata = 16'($urandom);
      if (addr == 4) wdata = 16'($urandom % 4);
      if (addr == 3 && $urandom % 4 != 0) wdata[0] = 1'b1;
      @(negedge clk);
    end
    rst = 0; wr_en = 0; rd_en = 0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/led_pwm.md
LED_PWM -- requirements
Module: led_pwm

Interface
REQ-001 SHALL have parameter PRESCALE_RST, default 16'd0, meaning reset value of PRESCALE register.
REQ-002 SHALL have parameter BLINK_PERIODS, default 64, meaning PWM periods per blink half-phase (range 1..255).
REQ-003 SHALL have parameter ACTIVE_LOW, default 1, meaning LED pins driven low when lit.
REQ-004 SHALL have ports, one clock, reset synchronous and active-high:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- wr_en  in  1  register write strobe
- rd_en  in  1  register read strobe
- addr  in  3  register offset
- wdata  in  16  write data
- rdata  out  16  read data
- rvalid  out  1  read data valid
- led_red  out  1  red LED pin
- led_green  out  1  green LED pin
- led_blue  out  1  blue LED pin

Function
REQ-005 SHALL implement register map: 0 DUTY_R[7:0], 1 DUTY_G[7:0], 2 DUTY_B[7:0], 3 CTRL ([0] enable, [1] blink_en), 4 PRESCALE[15:0], 5 STATUS read-only ([7:0] pwm_cnt, [8] blink_phase); 6-7 read 0, writes ignored.
REQ-006 SHALL ignore unused wdata bits on write; SHALL return unused bits as 0 on read.
REQ-007 SHALL present rdata and rvalid=1 exactly one cycle after rd_en; rvalid=0 otherwise; rdata holds last value when rvalid=0.
REQ-008 SHALL, on simultaneous rd_en and wr_en to the same address, return the pre-write value.
REQ-009 SHALL, while enable=1, run a 16-bit prescaler counting 0..PRESCALE, asserting tick when count==PRESCALE, then wrapping to 0; PRESCALE=0 gives tick every cycle.
REQ-010 SHALL reset prescaler count to 0 in the cycle following any PRESCALE write.
REQ-011 SHALL increment 8-bit pwm_cnt on each tick, wrapping 255->0.
REQ-012 SHALL double-buffer duty: writes update shadow DUTY_x; active duty loads from shadow only on the tick where pwm_cnt wraps 255->0.
REQ-013 SHALL compute channel lit = enable AND blink_on AND (pwm_cnt < active_duty); duty 0 never lit, duty 255 lit 255 of 256 steps.
REQ-014 SHALL register each LED pin one cycle after lit, driving lit XOR ACTIVE_LOW.
REQ-015 SHALL, when blink_en=1, count completed PWM periods and toggle blink_phase after BLINK_PERIODS wraps; blink_on = blink_phase==0.
REQ-016 SHALL, when blink_en=0, hold blink counter and blink_phase at 0 (blink_on=1).
REQ-017 SHALL, while enable=0, hold prescaler, pwm_cnt, blink counter and blink_phase at 0 and copy shadow duty into active duty every cycle.
REQ-018 SHALL, on enable 1->0 write, drive all pins unlit from the second cycle after the write.

Reset
REQ-019 SHALL on rst clear DUTY_x, active duty, CTRL, prescaler, pwm_cnt, blink state, rdata, rvalid to 0, and load PRESCALE with PRESCALE_RST.
REQ-020 SHALL drive all LED pins unlit (value ACTIVE_LOW) during and after reset until enabled.
REQ-021 SHALL give rst priority over wr_en and rd_en in the same cycle; rst mid-period aborts the period without glitching pins lit.

Structure
REQ-022 SHALL place register offsets, CTRL bit positions, and duty/prescale widths in shared package led_pwm_pkg.
REQ-023 SHALL instantiate sub-module led_pwm_channel three times (active-duty register, comparator, output register).

Verification
REQ-024 Reset, then read addr 4 with PRESCALE_RST=16'd3 -> rvalid=1 next cycle, rdata=16'h0003; all pins =1.
REQ-025 PRESCALE=0, DUTY_R=64, CTRL=1 -> led_red low for 64 of every 256 cycles, green/blue constantly high.
REQ-026 Write DUTY_G=200 mid-period with DUTY_G active 10 -> current period lit 10 steps, next period lit 200 steps.
REQ-027 CTRL=3, DUTY_B=255, BLINK_PERIODS=2, PRESCALE=0 -> led_blue alternates 512 cycles PWM-active, 512 cycles dark; STATUS[8] toggles every 512 cycles.
REQ-028 Same-cycle rd_en/wr_en addr 0, old 8'h11, new 8'h22 -> rdata=16'h0011, subsequent read 16'h0022.
REQ-029 Assert rst at pwm_cnt=100 with all channels lit -> pins high next cycle, STATUS reads 0 after release.
